// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter for the CPU IO page.
// Stores to DATA are queued in a small FIFO and shifted out on txd
// LSB first; STATUS exposes busy, full and a sticky overflow flag.
// io_rdata is registered so loads see the same one-cycle latency as RAM.

module uart_tx_mmio #(
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [1:0]  io_addr,
    input  logic [31:0] io_wdata,
    input  logic        io_wstrb,
    input  logic        io_rstrb,
    output logic [31:0] io_rdata,
    output logic        txd,
    output logic        busy
);

    // Clocks per bit, rounded to nearest.
    localparam int DIV    = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
    localparam int CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [FCNT_W-1:0] FULL_CNT  = FCNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Transmit FIFO
    // ------------------------------------------------------------------
    logic [7:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [7:0]        fifo_head;

    logic push_req;
    logic push_ok;
    logic drop;
    logic pop;
    logic status_rd;

    // Only the low byte of a store is transmitted.
    logic unused_wdata;
    assign unused_wdata = ^io_wdata[31:8];

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == FULL_CNT);
    assign fifo_head  = fifo_mem[rd_ptr];

    assign push_req  = io_wstrb && (io_addr == ADDR_DATA);
    // A pop on the same edge frees the slot being written, so a full
    // queue can still accept a byte then.
    assign push_ok   = push_req && (!fifo_full || pop);
    assign drop      = push_req && !push_ok;
    assign status_rd = io_rstrb && (io_addr == ADDR_STATUS);

    // Storage array: write-only on accepted pushes.
    // NOTE: the data array has no reset; count and pointers define which
    // entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= io_wdata[7:0];
        end
    end

    // Pointers and occupancy; pointers wrap naturally (depth is 2^n).
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Sticky overflow: a dropped byte sets it, a STATUS read clears it,
    // and a drop on the same edge as the read wins.
    logic overflow;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (status_rd) begin
            overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM
    // ------------------------------------------------------------------
    state_t            state,    state_d;
    logic [CNT_W-1:0]  baud_cnt, baud_d;
    logic [2:0]        bit_cnt,  bit_d;
    logic [7:0]        shift,    shift_d;
    logic              txd_q,    txd_d;
    logic              baud_done;

    assign baud_done = (baud_cnt == BAUD_LAST);

    // State register; txd is a flop so the line never glitches.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd_q    <= 1'b1;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
            txd_q    <= txd_d;
        end
    end

    // Next-state, next-txd and FIFO pop decision.
    // NOTE: every output of this block gets a default first, so no path
    // can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        txd_d   = txd_q;
        pop     = 1'b0;

        case (state)
            S_IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_head;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    txd_d   = shift[0];
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end

            S_DATA: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_cnt == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        shift_d = {1'b0, shift[7:1]};
                        txd_d   = shift[1];
                        bit_d   = bit_cnt + 1'b1;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end

            S_STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        pop     = 1'b1;
                        shift_d = fifo_head;
                        bit_d   = '0;
                        txd_d   = 1'b0;
                        state_d = S_START;
                    end else begin
                        txd_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_cnt + 1'b1;
                end
            end

            default: begin
                txd_d   = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    assign txd  = txd_q;
    assign busy = (state != S_IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // Register read port
    // ------------------------------------------------------------------
    // Loaded only on a read strobe and held until the next one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            io_rdata <= '0;
        end else if (io_rstrb) begin
            case (io_addr)
                ADDR_STATUS: io_rdata <= {29'b0, overflow, fifo_full, busy};
                default:     io_rdata <= '0;
            endcase
        end
    end

endmodule
